// File: rtl/dphy_byte_aligner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// dphy_byte_aligner - finds the HS sync byte at any bit offset in the
// deserialized lane stream and emits byte-aligned payload with a valid flag.
// Revision: 1.0
// ============================================================================
module dphy_byte_aligner #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned SYNC_TIMEOUT = 32
) (
  input  logic       byte_clk_i,
  input  logic       rst_n_i,
  input  logic       hs_en_i,
  input  logic [7:0] byte_data_i,
  output logic [7:0] byte_data_o,
  output logic       valid_o,
  output logic       sync_found_o,
  output logic       sync_err_o,
  output logic [2:0] offset_o
);

  localparam int unsigned      CNT_W    = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SYNC_TIMEOUT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HUNT    = 2'd1;
  localparam logic [1:0] ST_ALIGNED = 2'd2;
  localparam logic [1:0] ST_ERR     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             valid_q, valid_d;
  logic             sync_found_q, sync_found_d;
  logic             sync_err_q, sync_err_d;
  logic [2:0]       offset_q, offset_d;

  logic [15:0]      window;
  logic [7:0]       cand;
  logic             match;
  logic [2:0]       match_k;

  assign window = {byte_data_i, prev_q};
  assign cand   = window[offset_q +: 8];

  // Scan downwards so the lowest matching offset is the one left standing.
  always_comb begin
    match   = 1'b0;
    match_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (window[k +: 8] == SYNC_BYTE) begin
        match   = 1'b1;
        match_k = 3'(k);
      end
    end
  end

  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      prev_q       <= 8'h00;
      cnt_q        <= '0;
      byte_data_q  <= 8'h00;
      valid_q      <= 1'b0;
      sync_found_q <= 1'b0;
      sync_err_q   <= 1'b0;
      offset_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      prev_q       <= byte_data_i;
      cnt_q        <= cnt_d;
      byte_data_q  <= byte_data_d;
      valid_q      <= valid_d;
      sync_found_q <= sync_found_d;
      sync_err_q   <= sync_err_d;
      offset_q     <= offset_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (hs_en_i) state_d = ST_HUNT;
      ST_HUNT: begin
        if (!hs_en_i)              state_d = ST_IDLE;
        else if (match)            state_d = ST_ALIGNED;
        else if (cnt_q == CNT_LAST) state_d = ST_ERR;
      end
      ST_ALIGNED: if (!hs_en_i) state_d = ST_IDLE;
      ST_ERR:     if (!hs_en_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The match cycle itself never loads byte_data, so the sync byte is not emitted.
  always_comb begin
    cnt_d        = '0;
    byte_data_d  = byte_data_q;
    valid_d      = 1'b0;
    sync_found_d = 1'b0;
    sync_err_d   = 1'b0;
    offset_d     = offset_q;
    case (state_q)
      ST_HUNT: begin
        if (hs_en_i) begin
          if (match) begin
            offset_d     = match_k;
            sync_found_d = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            sync_err_d = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ALIGNED: begin
        valid_d      = hs_en_i;
        sync_found_d = hs_en_i;
        if (hs_en_i) byte_data_d = cand;
      end
      default: ;
    endcase
  end

  assign byte_data_o  = byte_data_q;
  assign valid_o      = valid_q;
  assign sync_found_o = sync_found_q;
  assign sync_err_o   = sync_err_q;
  assign offset_o     = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_dphy_byte_aligner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_dphy_byte_aligner - directed and randomized bursts against a bit-stream
// reference model of the byte aligner. Revision: 1.0
// ============================================================================
module tb_dphy_byte_aligner;

  localparam logic [7:0] SYNC = 8'hB8;
  localparam int         TMO  = 32;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs_en = 1'b0;
  logic [7:0] din   = 8'h00;
  logic [7:0] dout;
  logic       valid, found, err;
  logic [2:0] off;

  dphy_byte_aligner #(.SYNC_BYTE(SYNC), .SYNC_TIMEOUT(TMO)) dut (
    .byte_clk_i  (clk),
    .rst_n_i     (rst_n),
    .hs_en_i     (hs_en),
    .byte_data_i (din),
    .byte_data_o (dout),
    .valid_o     (valid),
    .sync_found_o(found),
    .sync_err_o  (err),
    .offset_o    (off)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: 0 idle, 1 hunting, 2 locked, 3 waiting after error
  int         m_mode = 0;
  int         m_hunt = 0;
  logic [7:0] m_prev = 8'h00, m_data = 8'h00;
  logic       m_valid = 1'b0, m_found = 1'b0, m_err = 1'b0;
  logic [2:0] m_off = 3'd0;

  logic [7:0] got[$];
  int         err_pulses = 0;
  int         first_found, first_valid, first_err, idx;
  logic [7:0] stream[$];
  logic [7:0] pay[$];

  function automatic int find_sync(logic [15:0] w);
    for (int k = 0; k < 8; k++)
      if (8'(w >> k) == SYNC) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hunt = 0; m_prev = 8'h00; m_data = 8'h00;
    m_valid = 1'b0; m_found = 1'b0; m_err = 1'b0; m_off = 3'd0;
  endtask

  task automatic model_tick(input logic h, input logic [7:0] d);
    logic [15:0] w;
    int hit;
    w   = {d, m_prev};
    hit = find_sync(w);
    m_err = 1'b0;
    case (m_mode)
      0: begin
        m_hunt = 0;
        if (h) m_mode = 1;
      end
      1: begin
        if (!h) begin
          m_mode = 0;
        end else if (hit >= 0) begin
          m_mode = 2; m_off = 3'(hit); m_found = 1'b1;
        end else begin
          m_hunt++;
          if (m_hunt == TMO) begin m_err = 1'b1; m_mode = 3; end
        end
      end
      2: begin
        if (h) begin
          m_data = 8'(w >> m_off); m_valid = 1'b1;
        end else begin
          m_valid = 1'b0; m_found = 1'b0; m_mode = 0;
        end
      end
      default: if (!h) m_mode = 0;
    endcase
    m_prev = d;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_model();
    checks++;
    if ({dout, valid, found, err, off} !== {m_data, m_valid, m_found, m_err, m_off}) begin
      errors++;
      $display("FAIL model cycle %0d actual data=%h v=%b f=%b e=%b off=%0d required data=%h v=%b f=%b e=%b off=%0d",
               cyc, dout, valid, found, err, off, m_data, m_valid, m_found, m_err, m_off);
    end
    if (valid === 1'b1) got.push_back(dout);
    if (err === 1'b1) err_pulses++;
  endtask

  // Called at the negedge: apply inputs, advance one clock, compare at next negedge.
  task automatic step(input logic h, input logic [7:0] d);
    hs_en = h;
    din   = d;
    @(posedge clk);
    if (rst_n) model_tick(h, d);
    else       model_reset();
    @(negedge clk);
    cyc++;
    cmp_model();
  endtask

  task automatic build(input int k, input int npre, input bit rnd);
    bit bits[$];
    logic [7:0] b, sb;
    stream.delete();
    sb = SYNC;
    for (int i = 0; i < npre; i++) begin
      b = rnd ? 8'($urandom) : 8'h00;
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
    end
    for (int i = 0; i < k; i++) bits.push_back(1'b0);
    for (int j = 0; j < 8; j++) bits.push_back(sb[j]);
    foreach (pay[p]) begin
      b = pay[p];
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
    end
    while ((bits.size() % 8) != 0) bits.push_back(1'b0);
    for (int j = 0; j < 8; j++) bits.push_back(1'b0);
    for (int i = 0; i < bits.size() / 8; i++) begin
      for (int j = 0; j < 8; j++) b[j] = bits[i*8 + j];
      stream.push_back(b);
    end
  endtask

  task automatic send_stream();
    first_found = -1; first_valid = -1; first_err = -1;
    got.delete();
    for (int i = 0; i < stream.size(); i++) begin
      step(1'b1, stream[i]);
      if (found === 1'b1 && first_found < 0) first_found = i;
      if (valid === 1'b1 && first_valid < 0) first_valid = i;
    end
  endtask

  task automatic go_idle();
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    model_reset();
    chk("reset_outputs", {23'd0, dout, valid, found, err, off}, 32'd0);
    rst_n = 1'b1;
    go_idle();

    // Offset 0
    pay = '{8'h12, 8'h34, 8'h56};
    build(0, 2, 1'b0);
    send_stream();
    chk("off0_offset", {29'd0, off}, 32'd0);
    chk("off0_found_at", first_found, 3);
    chk("off0_nbytes_ge3", got.size() >= 3, 1);
    if (got.size() >= 3) begin
      chk("off0_b0", got[0], 8'h12);
      chk("off0_b1", got[1], 8'h34);
      chk("off0_b2", got[2], 8'h56);
    end
    go_idle();

    // Offset 3
    pay = '{8'h12, 8'h34};
    build(3, 2, 1'b0);
    chk("off3_stream2", stream[2], 8'hC0);
    chk("off3_stream3", stream[3], 8'h95);
    send_stream();
    chk("off3_offset", {29'd0, off}, 32'd3);
    chk("off3_found_at", first_found, 3);
    chk("off3_valid_at", first_valid, 4);
    if (got.size() >= 2) begin
      chk("off3_b0", got[0], 8'h12);
      chk("off3_b1", got[1], 8'h34);
    end else chk("off3_nbytes", got.size(), 2);
    go_idle();

    // Timeout then relock
    err_pulses = 0; got.delete(); first_err = -1;
    for (int i = 0; i < 36; i++) begin
      step(1'b1, 8'h00);
      if (err === 1'b1 && first_err < 0) first_err = i;
    end
    chk("tmo_pulses", err_pulses, 1);
    chk("tmo_pulse_at", first_err, 32);
    chk("tmo_no_valid", got.size(), 0);
    go_idle();
    pay = '{8'hA5};
    build(0, 2, 1'b0);
    send_stream();
    chk("tmo_relock", found, 1'b1);
    chk("tmo_relock_byte", got.size() >= 1 ? got[0] : 8'hXX, 8'hA5);
    go_idle();

    // Burst end at offset 5, re-hunt at offset 2
    pay.delete();
    for (int i = 0; i < 10; i++) pay.push_back(8'($urandom));
    build(5, 2, 1'b0);
    send_stream();
    chk("end_offset", {29'd0, off}, 32'd5);
    chk("end_nbytes_ge10", got.size() >= 10, 1);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("end_payload", got[i], pay[i]);
    step(1'b0, 8'h00);
    chk("end_valid_drop", valid, 1'b0);
    chk("end_found_drop", found, 1'b0);
    step(1'b0, 8'h00);
    pay = '{8'h3C, 8'hC3};
    build(2, 2, 1'b0);
    send_stream();
    chk("rehunt_offset", {29'd0, off}, 32'd2);
    if (got.size() >= 1) chk("rehunt_b0", got[0], 8'h3C);
    else chk("rehunt_nbytes", got.size(), 1);
    go_idle();

    // hs_en falls in the match cycle
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, SYNC);
    step(1'b0, 8'h12);
    chk("fall_match_nolock", found, 1'b0);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    chk("fall_match_nolock2", found, 1'b0);
    go_idle();

    // Match coincides with timeout cycle
    err_pulses = 0;
    step(1'b1, 8'h00);
    for (int i = 0; i < 30; i++) step(1'b1, 8'h00);
    step(1'b1, SYNC);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    chk("coincide_found", found, 1'b1);
    chk("coincide_no_err", err_pulses, 0);
    go_idle();

    // Asynchronous reset while aligned
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    build(4, 2, 1'b0);
    send_stream();
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", {23'd0, dout, valid, found, err, off}, 32'd0);
    @(negedge clk);
    step(1'b1, 8'h00);
    rst_n = 1'b1;
    pay = '{8'h5A};
    build(1, 2, 1'b0);
    send_stream();
    chk("post_reset_lock", found, 1'b1);
    chk("post_reset_offset", {29'd0, off}, 32'd1);
    go_idle();

    // Randomized bursts, checked every cycle by the model
    for (int b = 0; b < 40; b++) begin
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) step(1'b0, 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < int'($urandom_range(30, 40)); i++) step(1'b1, 8'($urandom) & 8'h0F);
      end else begin
        pay.delete();
        for (int i = 0; i < int'($urandom_range(0, 12)); i++) pay.push_back(8'($urandom));
        build(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1);
        for (int i = 0; i < stream.size(); i++) step(1'b1, stream[i]);
        for (int i = 0; i < int'($urandom_range(0, 5)); i++) step(1'b1, 8'($urandom));
      end
    end
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
